// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
//
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   in_valid / in_ready        upstream handshake
//   instr_ID, op_a, op_b, rd   opcode (1..12), operands and destination tag
//   out_valid / out_ready      downstream handshake
//   out_result, out_rd         computed value and carried tag
//   out_we, out_ovf, out_ill   writeback enable, signed overflow, illegal opcode
//   retired_cnt                wrapping count of consumed results
//
// S1 holds the raw operation; the ALU evaluates S1 combinationally and S2
// registers the result and flags.
module alu_pipe #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr_ID,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [TAG_W-1:0] rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_rd,
    output logic             out_we,
    output logic             out_ovf,
    output logic             out_ill,
    output logic [CNT_W-1:0] retired_cnt
);

    // Stage S1 state
    logic             r_s1_valid;
    logic [31:0]      r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [TAG_W-1:0] r_s1_rd;

    // Stage S2 state
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_result;
    logic [TAG_W-1:0] r_s2_rd;
    logic             r_s2_we;
    logic             r_s2_ovf;
    logic             r_s2_ill;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s2_free;
    logic             w_consume;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [WIDTH-1:0] w_result;
    logic             w_ovf;
    logic             w_ill;

    assign w_s2_free = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign w_consume = r_s2_valid && out_ready;

    assign w_sum  = r_s1_a + r_s1_b;
    assign w_diff = r_s1_a - r_s1_b;

    // Add: like-signed operands producing a differently-signed sum.
    assign w_add_ovf = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
    // Sub: unlike-signed operands with the result sign departing from op_a.
    assign w_sub_ovf = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != r_s1_a[WIDTH-1]);

    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        w_ill    = 1'b0;
        case (r_s1_op)
            32'd1, 32'd5: begin
                w_result = w_sum;
                w_ovf    = w_add_ovf;
            end
            32'd3, 32'd6: w_result = w_sum;
            32'd2: begin
                w_result = w_diff;
                w_ovf    = w_sub_ovf;
            end
            32'd4:         w_result = w_diff;
            32'd7, 32'd9:  w_result = r_s1_a & r_s1_b;
            32'd8, 32'd10: w_result = r_s1_a | r_s1_b;
            32'd11:        w_result = r_s1_a << r_s1_b[SHAMT_W-1:0];
            32'd12:        w_result = r_s1_a >> r_s1_b[SHAMT_W-1:0];
            default:       w_ill    = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_rd    <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            r_s1_op    <= instr_ID;
            r_s1_a     <= op_a;
            r_s1_b     <= op_b;
            r_s1_rd    <= rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_rd     <= '0;
            r_s2_we     <= 1'b0;
            r_s2_ovf    <= 1'b0;
            r_s2_ill    <= 1'b0;
        end else if (w_s2_free) begin
            r_s2_valid  <= r_s1_valid;
            r_s2_result <= w_result;
            r_s2_rd     <= r_s1_rd;
            r_s2_we     <= !w_ovf && !w_ill;
            r_s2_ovf    <= w_ovf;
            r_s2_ill    <= w_ill;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_consume) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid   = r_s2_valid;
    assign out_result  = r_s2_result;
    assign out_rd      = r_s2_rd;
    assign out_we      = r_s2_we;
    assign out_ovf     = r_s2_ovf;
    assign out_ill     = r_s2_ill;
    assign retired_cnt = r_cnt;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr_ID;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_ovf;
    logic        out_ill;
    logic [15:0] retired_cnt;

    // Narrow-counter instance sharing all inputs, for the wrap check.
    logic        c4_in_ready;
    logic        c4_out_valid;
    logic [31:0] c4_out_result;
    logic [4:0]  c4_out_rd;
    logic        c4_out_we;
    logic        c4_out_ovf;
    logic        c4_out_ill;
    logic [3:0]  c4_retired_cnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    alu_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr_ID(instr_ID), .op_a(op_a), .op_b(op_b), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_we(out_we), .out_ovf(out_ovf), .out_ill(out_ill),
        .retired_cnt(retired_cnt)
    );

    alu_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c4_in_ready),
        .instr_ID(instr_ID), .op_a(op_a), .op_b(op_b), .rd(rd),
        .out_valid(c4_out_valid), .out_ready(out_ready), .out_result(c4_out_result),
        .out_rd(c4_out_rd), .out_we(c4_out_we), .out_ovf(c4_out_ovf),
        .out_ill(c4_out_ill), .retired_cnt(c4_retired_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One op through an otherwise empty pipe with out_ready held high.
    task automatic run_op(input string tag, input logic [31:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t,
                          input logic [31:0] exp_res, input logic exp_ovf,
                          input logic exp_ill);
        in_valid  = 1'b1;
        instr_ID  = op;
        op_a      = a;
        op_b      = b;
        rd        = t;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat0"}, out_valid, 1'b0);
        tick();
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_res"}, out_result, exp_res);
        chk({tag, "_rd"}, out_rd, t);
        chk({tag, "_ovf"}, out_ovf, exp_ovf);
        chk({tag, "_ill"}, out_ill, exp_ill);
        chk({tag, "_we"}, out_we, !exp_ovf && !exp_ill);
        exp_cnt++;
        tick();
        chk({tag, "_cnt"}, retired_cnt, 16'(exp_cnt));
        chk({tag, "_drain"}, out_valid, 1'b0);
    endtask

    initial begin
        int occ;
        int next_tag;
        int got;
        bit saw_full;
        bit prev_stall;
        logic [4:0]  held_rd;
        logic [31:0] held_res;
        bit acc;
        bit con;

        reset     = 1'b1;
        in_valid  = 1'b0;
        instr_ID  = 32'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        rd        = 5'd0;
        out_ready = 1'b0;
        exp_cnt   = 0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        tick();
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_cnt", retired_cnt, 16'd0);
        chk("rst_flags", {out_we, out_ovf, out_ill}, 3'b000);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        tick();

        // Directed single operations
        run_op("add",    32'd1,  32'd5,          32'd7,          5'd3,  32'd12,         0, 0);
        run_op("add_ov", 32'd1,  32'h7FFF_FFFF,  32'd1,          5'd4,  32'h8000_0000,  1, 0);
        run_op("sub_ov", 32'd2,  32'h8000_0000,  32'd1,          5'd5,  32'h7FFF_FFFF,  1, 0);
        run_op("sub",    32'd2,  32'd10,         32'd3,          5'd6,  32'd7,          0, 0);
        run_op("addu",   32'd3,  32'hFFFF_FFFF,  32'd1,          5'd7,  32'd0,          0, 0);
        run_op("subu",   32'd4,  32'd3,          32'd5,          5'd8,  32'hFFFF_FFFE,  0, 0);
        run_op("addi_ov",32'd5,  32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h7FFF_FFFF,  1, 0);
        run_op("addiu",  32'd6,  32'h7FFF_FFFF,  32'd1,          5'd10, 32'h8000_0000,  0, 0);
        run_op("and",    32'd7,  32'h0000_F0F0,  32'h0000_0FF0,  5'd11, 32'h0000_00F0,  0, 0);
        run_op("or",     32'd8,  32'h0000_F000,  32'h0000_000F,  5'd12, 32'h0000_F00F,  0, 0);
        run_op("andi",   32'd9,  32'hFFFF_FFFF,  32'h0000_1234,  5'd13, 32'h0000_1234,  0, 0);
        run_op("ori",    32'd10, 32'h0000_0000,  32'h0000_FFFF,  5'd14, 32'h0000_FFFF,  0, 0);
        run_op("sll",    32'd11, 32'h0000_0001,  32'h0000_0021,  5'd15, 32'h0000_0002,  0, 0);
        run_op("srl",    32'd12, 32'h8000_0000,  32'd31,         5'd16, 32'h0000_0001,  0, 0);
        run_op("ill0",   32'd0,  32'd5,          32'd6,          5'd17, 32'd0,          0, 1);
        run_op("ill13",  32'd13, 32'd5,          32'd6,          5'd18, 32'd0,          0, 1);

        // Backpressure: tags 1..6, out_ready low for 4 cycles mid-stream.
        occ        = 0;
        next_tag   = 1;
        got        = 0;
        saw_full   = 0;
        prev_stall = 0;
        held_rd    = '0;
        held_res   = '0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            in_valid  = (next_tag <= 6);
            instr_ID  = 32'd3;
            op_a      = 32'(next_tag);
            op_b      = 32'd100;
            rd        = 5'(next_tag);
            out_ready = !(c >= 3 && c < 7);
            #1;
            chk("bp_in_ready", in_ready, !(occ == 2 && !out_ready));
            if (!in_ready) saw_full = 1;
            if (out_valid && !out_ready) begin
                if (prev_stall) begin
                    chk("bp_hold_rd", out_rd, held_rd);
                    chk("bp_hold_res", out_result, held_res);
                end
                prev_stall = 1;
                held_rd    = out_rd;
                held_res   = out_result;
            end else begin
                prev_stall = 0;
            end
            acc = in_valid && in_ready;
            con = out_valid && out_ready;
            if (con) begin
                got++;
                chk("bp_order", out_rd, 5'(got));
                chk("bp_res", out_result, 32'(got + 100));
                exp_cnt++;
            end
            tick();
            if (acc) begin
                occ++;
                next_tag++;
            end
            if (con) occ--;
        end
        in_valid = 1'b0;
        chk("bp_all_out", got, 6);
        chk("bp_saw_full", saw_full, 1'b1);
        tick();
        chk("bp_no_dup", out_valid, 1'b0);
        chk("bp_cnt", retired_cnt, 16'(exp_cnt));

        // Reset with both stages full.
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr_ID  = 32'd1;
        op_a      = 32'd1;
        op_b      = 32'd2;
        rd        = 5'd20;
        tick();
        rd = 5'd21;
        tick();
        in_valid = 1'b0;
        #1;
        chk("full_valid", out_valid, 1'b1);
        chk("full_in_ready", in_ready, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_cnt", retired_cnt, 16'd0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_empty", out_valid, 1'b0);
        end

        // Counter wrap on the CNT_W=4 instance: 17 consumes.
        in_valid = 1'b1;
        instr_ID = 32'd7;
        for (int i = 0; i < 17; i++) begin
            rd = 5'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("wrap_cnt4", c4_retired_cnt, 4'd1);
        chk("wrap_cnt16", retired_cnt, 16'd17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined successor to the combinational ALU. It executes the 12-opcode ALU set (`instr_ID` 1–12) on a WIDTH-bit datapath behind valid/ready handshakes on both sides. Results carry a destination tag, a write-enable and signed-overflow and illegal-opcode flags. A wrapping counter tracks retired operations. The block sits between the decode/register-read stage (upstream) and register writeback (downstream).

## Interface
- `WIDTH`, 32, datapath width in bits (≥ 8)
- `SHAMT_W`, 5, shift-amount bits taken from `op_b` (2^SHAMT_W ≤ WIDTH)
- `TAG_W`, 5, destination-register tag width
- `CNT_W`, 16, retired-operation counter width
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  upstream offers an operation
- `in_ready`  out  1  block accepts the operation this cycle
- `instr_ID`  in  32  opcode, 1..12 as listed under Operation
- `op_a`  in  WIDTH  first operand (rs)
- `op_b`  in  WIDTH  second operand (rt, or immediate already extended by the caller)
- `rd`  in  TAG_W  destination tag
- `out_valid`  out  1  result presented
- `out_ready`  in  1  downstream consumes the result
- `out_result`  out  WIDTH  computed value
- `out_rd`  out  TAG_W  tag carried from input
- `out_we`  out  1  writeback permitted
- `out_ovf`  out  1  signed overflow (opcodes 1, 2, 5)
- `out_ill`  out  1  opcode outside 1..12
- `retired_cnt`  out  CNT_W  count of results consumed (`out_valid && out_ready`)

## Operation
- Opcodes:
  - 1 add, 2 sub: signed; overflow detected.
  - 3 addu, 4 subu: no overflow detection.
  - 5 addi: signed; overflow detected.
  - 6 addiu: no overflow detection.
  - 7 and, 8 or.
  - 9 andi, 10 ori: same logic as 7 and 8.
  - 11 sll: `op_a << op_b[SHAMT_W-1:0]`, logical.
  - 12 srl: `op_a >> op_b[SHAMT_W-1:0]`, logical.
- Arithmetic is modulo 2^WIDTH. The upper bits of `op_b` are ignored for shifts.
- Signed overflow:
  - Add (1, 5): operands have the same sign and the result sign differs.
  - Sub (2): operands have different signs and the result sign differs from `op_a`.
- On overflow: `out_ovf`=1, `out_we`=0, and `out_result` still holds the wrapped value.
- Illegal opcode (0 or ≥13): `out_result`=0, `out_ill`=1, `out_we`=0. The operation still flows through and is counted.
- Otherwise `out_we`=1 and both flags are 0.
- Stage S1 registers `instr_ID`, `op_a`, `op_b`, `rd` and a valid bit.
- Stage S2 registers the result, tag and flags, plus `out_valid`.
- Advance rules:
  - `s2_free = !out_valid || out_ready`
  - `in_ready = !s1_valid || s2_free`
- S2 loads from S1 when `s2_free`. Its valid becomes `s1_valid`.
- S1 loads the inputs when `in_ready`. Its valid becomes `in_valid`.
- Stalled stages hold all contents unchanged. No operation is dropped or duplicated.
- `retired_cnt` increments by 1 on each consume and wraps from 2^CNT_W−1 to 0.

## Timing
- Reset asserted: asynchronously clears `s1_valid`, `out_valid`, `out_result`, `out_rd`, `out_we`, `out_ovf`, `out_ill` and `retired_cnt` to 0.
- `in_ready` is 1 throughout reset and after reset, since S1 is empty.
- Reset mid-operation: all in-flight operations are discarded. Nothing is presented after release.
- Latency: an operation accepted on edge k has `out_valid`=1 after edge k+1.
- Throughput: 1 operation per cycle while `out_ready`=1.
- `in_ready` depends combinationally on `out_ready`. There is no path from `in_valid` to `in_ready`.
- Full condition: both stages valid and `out_ready`=0. Then `in_ready`=0, and S1 and S2 hold.
- Simultaneous consume and refill: with both stages full and `out_ready`=1, on the same edge S2 takes S1, S1 takes a new input, and the counter increments.
- `out_*` fields are stable while `out_valid`=1 and `out_ready`=0.
- Empty pipe with `in_valid`=0: `out_valid` falls after the last consume.

## Test plan
- Reset then one op: `add` 5 + 7, rd=3, `out_ready`=1 → 2 edges later `out_result`=12, `out_rd`=3, `out_we`=1, flags 0, then `retired_cnt`=1.
- Overflow: `add` 0x7FFFFFFF + 1 → `out_result`=0x80000000, `out_ovf`=1, `out_we`=0. `sub` 0x80000000 − 1 → `out_ovf`=1. `addu` 0xFFFFFFFF + 1 → result 0, `out_ovf`=0.
- Shifts and logic:
  - `sll` 0x1 by `op_b`=0x21 → 0x2 (only 5 bits used).
  - `srl` 0x80000000 by 31 → 0x1.
  - `and` 0xF0F0 & 0x0FF0 → 0x00F0.
  - `ori` 0x0 | 0xFFFF → 0xFFFF.
- Illegal: `instr_ID`=0 and `instr_ID`=13 → `out_result`=0, `out_ill`=1, `out_we`=0, counter still increments.
- Backpressure: stream tags 1..6 back-to-back, hold `out_ready`=0 for 4 cycles mid-stream → `in_ready` drops once 2 ops are held. Outputs are stable, and all 6 tags emerge in order exactly once. `retired_cnt`=6.
- Reset mid-stream plus wrap:
  - Assert `reset` with both stages full → `out_valid`=0 immediately and no stale result after release.
  - With CNT_W=4, consume 17 ops → `retired_cnt`=1.
